// File: rtl/i2c_req_arbiter_pkg.sv
// i2c_arb_pkg: state encodings and default sizes shared by the I2C request arbiter.
package i2c_arb_pkg;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_ISSUE = 4'b0010;
    localparam logic [3:0] S_WAIT  = 4'b0100;
    localparam logic [3:0] S_RESP  = 4'b1000;

    localparam int ADDR_LEN_DEF       = 7;
    localparam int DATA_LEN_DEF       = 8;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester, response and engine signals of the arbiter; master = arbiter side.
interface i2c_req_arbiter_if
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
    logic [NUM_REQ-1:0]          req_rw;
    logic [NUM_REQ*DATA_LEN-1:0] req_wdata;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_LEN-1:0]         rsp_rdata;
    logic                        rsp_nack;
    logic                        rsp_timeout;
    logic                        eng_start;
    logic [ADDR_LEN-1:0]         eng_addr;
    logic                        eng_rw;
    logic [DATA_LEN-1:0]         eng_wdata;
    logic                        eng_abort;
    logic                        eng_busy;
    logic                        eng_done;
    logic [DATA_LEN-1:0]         eng_rdata;
    logic                        eng_nack;

    modport master (
        input  req_valid, req_addr, req_rw, req_wdata, eng_busy, eng_done, eng_rdata, eng_nack,
        output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        output eng_start, eng_addr, eng_rw, eng_wdata, eng_abort
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_wdata, eng_busy, eng_done, eng_rdata, eng_nack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
        input  eng_start, eng_addr, eng_rw, eng_wdata, eng_abort
    );

endinterface

// File: rtl/i2c_req_arbiter_picker.sv
// rr_priority_picker: first set request scanning upward from rr_ptr with wrap; one-hot grant plus index.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            j   = sum >= SW'(NUM_REQ) ? IW'(sum - SW'(NUM_REQ)) : IW'(sum);
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C byte engine; I2C_ARB_TIMEOUT_EN adds a WAIT watchdog.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_LEN       = ADDR_LEN_DEF,
    parameter int DATA_LEN       = DATA_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic               clk,
    input logic               rst_n,
    i2c_req_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("i2c_req_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    logic [3:0]          state;
    logic [IW-1:0]       rr_ptr, win_idx, pick_idx;
    logic [NUM_REQ-1:0]  pick_oh, win_oh;
    logic [ADDR_LEN-1:0] sel_addr;
    logic                sel_rw;
    logic [DATA_LEN-1:0] sel_wdata;
    logic                expire;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req_valid(bus.req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (pick_oh),
        .idx      (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                sel_addr  = bus.req_addr[k*ADDR_LEN +: ADDR_LEN];
                sel_rw    = bus.req_rw[k];
                sel_wdata = bus.req_wdata[k*DATA_LEN +: DATA_LEN];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt;

    // Held at zero outside WAIT, so it reads 0 on the first WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt <= '0;
        else        to_cnt <= state == S_WAIT ? to_cnt + CW'(1) : '0;
    end

    assign expire = state == S_WAIT && to_cnt == CW'(TIMEOUT_CYCLES - 1) && !bus.eng_done;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            win_idx         <= '0;
            win_oh          <= '0;
            bus.eng_addr    <= '0;
            bus.eng_rw      <= 1'b0;
            bus.eng_wdata   <= '0;
            bus.eng_start   <= 1'b0;
            bus.eng_abort   <= 1'b0;
            bus.req_ready   <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_nack    <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.eng_start <= 1'b0;
            bus.eng_abort <= 1'b0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            if (state == S_IDLE && |bus.req_valid && !bus.eng_busy) begin
                state         <= S_ISSUE;
                win_idx       <= pick_idx;
                win_oh        <= pick_oh;
                bus.eng_addr  <= sel_addr;
                bus.eng_rw    <= sel_rw;
                bus.eng_wdata <= sel_wdata;
                bus.eng_start <= 1'b1;
                bus.req_ready <= pick_oh;
            end
            if (state == S_ISSUE) state <= S_WAIT;
            if (state == S_WAIT && (bus.eng_done || expire)) begin
                state           <= S_RESP;
                bus.rsp_valid   <= win_oh;
                bus.rsp_rdata   <= expire || !bus.eng_rw ? '0 : bus.eng_rdata;
                bus.rsp_nack    <= expire || bus.eng_nack;
                bus.rsp_timeout <= expire;
                bus.eng_abort   <= expire;
            end
            if (state == S_RESP) begin
                state  <= S_IDLE;
                rr_ptr <= win_idx == IW'(NUM_REQ - 1) ? '0 : win_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: scoreboard bench with an engine model; timeout case built only with I2C_ARB_TIMEOUT_EN.
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int N  = 4;
    localparam int AL = 7;
    localparam int DL = 8;
    localparam int TO = 16;

    typedef struct {
        logic [N-1:0]  oh;
        logic [AL-1:0] addr;
        logic          rw;
        logic [DL-1:0] wdata;
        logic [DL-1:0] rdata;
        logic          nack;
        logic          to;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    i2c_req_arbiter_if #(.NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

    i2c_req_arbiter #(.NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    txn_t          gq[$];
    txn_t          rq[$];
    int            n_vec = 0, n_err = 0, cyc = 0, n_grant = 0;
    int            pend[N];
    int            lat = 1, done_at = -1, start_cyc = -1, done_cyc = -1, g0 = 0;
    logic [DL-1:0] eng_rd = '0;
    logic          eng_nk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic post(input int i, input logic [AL-1:0] a, input logic rw, input logic [DL-1:0] wd, input int n);
        bus.req_addr[i*AL +: AL]  = a;
        bus.req_rw[i]             = rw;
        bus.req_wdata[i*DL +: DL] = wd;
        pend[i]                   = n;
        bus.req_valid[i]          = n > 0;
    endtask

    task automatic expect_txn(input int i, input logic [DL-1:0] rd, input logic nk, input logic to);
        txn_t t;
        t.oh    = N'(1) << i;
        t.addr  = bus.req_addr[i*AL +: AL];
        t.rw    = bus.req_rw[i];
        t.wdata = bus.req_wdata[i*DL +: DL];
        t.rdata = (to || !t.rw) ? '0 : rd;
        t.nack  = nk || to;
        t.to    = to;
        gq.push_back(t);
    endtask

    task automatic step();
        txn_t t;
        @(negedge clk);
        cyc++;
        if (bus.req_ready != '0 || bus.eng_start) begin
            n_grant++;
            if (gq.size() == 0) check("unexpected_grant", 32'(bus.req_ready), 32'(0));
            else begin
                t = gq.pop_front();
                check("req_ready", 32'(bus.req_ready), 32'(t.oh));
                check("eng_start", 32'(bus.eng_start), 32'(1));
                check("eng_addr", 32'(bus.eng_addr), 32'(t.addr));
                check("eng_rw", 32'(bus.eng_rw), 32'(t.rw));
                check("eng_wdata", 32'(bus.eng_wdata), 32'(t.wdata));
                rq.push_back(t);
            end
            start_cyc = cyc;
            done_at   = lat < 0 ? -1 : cyc + lat;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    pend[i]--;
                    if (pend[i] <= 0) bus.req_valid[i] = 1'b0;
                end
            end
        end
        if (bus.rsp_valid != '0) begin
            if (rq.size() == 0) check("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
            else begin
                t = rq.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'(t.oh));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(t.rdata));
                check("rsp_nack", 32'(bus.rsp_nack), 32'(t.nack));
                check("rsp_timeout", 32'(bus.rsp_timeout), 32'(t.to));
                check("eng_abort", 32'(bus.eng_abort), 32'(t.to));
                if (t.to) check("abort_lat", 32'(cyc - (start_cyc + 1)), 32'(TO));
                else      check("rsp_lat", 32'(cyc - done_cyc), 32'(1));
            end
        end
        bus.eng_done  = cyc == done_at;
        bus.eng_rdata = bus.eng_done ? eng_rd : 8'hFF;
        bus.eng_nack  = bus.eng_done ? eng_nk : !eng_nk;
        if (bus.eng_done) done_cyc = cyc;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && gq.size() + rq.size() != 0; k++) step();
        check("drain", 32'(gq.size() + rq.size()), 32'(0));
    endtask

    task automatic check_reset_outs();
        check("rst_pulses", 32'({bus.req_ready, bus.rsp_valid, bus.eng_start, bus.eng_abort}), 32'(0));
        check("rst_rsp", 32'({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}), 32'(0));
        check("rst_eng", 32'({bus.eng_addr, bus.eng_rw, bus.eng_wdata}), 32'(0));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_rw    = '0;
        bus.req_wdata = '0;
        bus.eng_busy  = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_rdata = '0;
        bus.eng_nack  = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (2) step();
        check_reset_outs();
        rst_n = 1'b1;

        // Fairness: every requester held, requester 0 wants two bytes
        lat = 3; eng_rd = 8'h77; eng_nk = 1'b0;
        post(0, 7'h10, 1'b0, 8'h30, 2);
        post(1, 7'h11, 1'b1, 8'h31, 1);
        post(2, 7'h12, 1'b0, 8'h32, 1);
        post(3, 7'h13, 1'b1, 8'h33, 1);
        for (int i = 0; i < N; i++) expect_txn(i, eng_rd, eng_nk, 1'b0);
        expect_txn(0, eng_rd, eng_nk, 1'b0);
        drain(200);

        lat = 20; eng_rd = 8'hEE; eng_nk = 1'b0;
        post(2, 7'h5B, 1'b0, 8'hA5, 1);
        expect_txn(2, eng_rd, eng_nk, 1'b0);
        drain(100);
        check("done_lat", 32'(done_cyc - start_cyc), 32'(20));

        lat = 5; eng_rd = 8'h3C; eng_nk = 1'b1;
        post(1, 7'h20, 1'b1, 8'h00, 1);
        expect_txn(1, eng_rd, eng_nk, 1'b0);
        drain(100);

        // rr_ptr is 2 here, so requester 3 beats requester 0
        bus.eng_busy = 1'b1;
        lat = 4; eng_rd = 8'h5A; eng_nk = 1'b0;
        post(3, 7'h33, 1'b1, 8'h00, 1);
        post(0, 7'h40, 1'b0, 8'h99, 1);
        g0 = n_grant;
        repeat (6) step();
        check("busy_no_grant", 32'(n_grant - g0), 32'(0));
        expect_txn(3, eng_rd, eng_nk, 1'b0);
        expect_txn(0, eng_rd, eng_nk, 1'b0);
        bus.eng_busy = 1'b0;
        step();
        check("busy_grant_lat", 32'(n_grant - g0), 32'(1));
        drain(100);

`ifdef I2C_ARB_TIMEOUT_EN
        lat = -1; eng_rd = 8'hCC; eng_nk = 1'b0;
        post(2, 7'h5B, 1'b1, 8'h00, 1);
        expect_txn(2, eng_rd, eng_nk, 1'b1);
        drain(100);
`endif

        // Reset while WAIT is stuck; rr_ptr is 1 beforehand
        lat = -1;
        post(1, 7'h2A, 1'b0, 8'h66, 1);
        expect_txn(1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 10 && gq.size() != 0; k++) step();
        repeat (2) step();
        check("stuck_in_wait", 32'(rq.size()), 32'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        gq.delete();
        rq.delete();
        for (int i = 0; i < N; i++) pend[i] = 0;
        bus.req_valid = '0;
        done_at = -1;
        repeat (2) step();
        rst_n = 1'b1;
        lat = 3; eng_rd = 8'h81; eng_nk = 1'b0;
        post(0, 7'h50, 1'b1, 8'h00, 1);
        post(3, 7'h53, 1'b0, 8'h44, 1);
        expect_txn(0, eng_rd, eng_nk, 1'b0);
        expect_txn(3, eng_rd, eng_nk, 1'b0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
